// File: rtl/dmem_wait.sv
// Word-organised data RAM with a valid/ready request port, a fixed number of
// wait states, byte/half/word lanes and alignment/range error reporting.
module dmem_wait #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic        signed_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        access;
  logic        out_range;
  logic        misaligned;
  logic        access_err;
  logic [AW-1:0] mem_idx;
  logic [31:0] word_idx;
  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [3:0]  lane_mask;
  logic [7:0]  wlane [4];

  assign accept    = (state_reg == IDLE) && req_valid;
  assign access    = (state_reg == WAIT) && (cnt_reg == 4'd0);
  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only on acceptance, so later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      signed_reg <= 1'b0;
      size_reg   <= 2'b00;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      rdata_reg  <= 32'h0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg     <= req_we;
        signed_reg <= req_signed;
        size_reg   <= req_size;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
      end
      if (access) begin
        err_reg   <= access_err;
        rdata_reg <= (access_err || we_reg) ? 32'h0 : load_data;
      end
    end
  end

  assign word_idx   = {2'b00, addr_reg[31:2]};
  assign out_range  = word_idx >= 32'(DEPTH);
  assign misaligned = ((size_reg == 2'b01) && addr_reg[0]) ||
                      ((size_reg == 2'b10) && (addr_reg[1:0] != 2'b00));
  assign access_err = (size_reg == 2'b11) || misaligned || out_range;
  assign mem_idx    = addr_reg[AW+1:2];

  // Store data arrives right-justified; replicate it across the lanes it may target.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[gi] = (size_reg == 2'b10) ||
                             ((size_reg == 2'b01) && (addr_reg[1] == 1'(gi / 2))) ||
                             ((size_reg == 2'b00) && (addr_reg[1:0] == 2'(gi)));
      assign wlane[gi] = (size_reg == 2'b00) ? wdata_reg[7:0] :
                         (size_reg == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                               wdata_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (access && we_reg && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) begin
          mem[mem_idx][8*i +: 8] <= wlane[i];
        end
      end
    end
  end

  always_comb begin
    rd_word   = mem[mem_idx];
    ld_byte   = rd_word[{addr_reg[1:0], 3'b000} +: 8];
    ld_half   = rd_word[{addr_reg[1], 4'b0000} +: 16];
    load_data = rd_word;
    case (size_reg)
      2'b00:   load_data = signed_reg ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      2'b01:   load_data = signed_reg ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: load_data = rd_word;
    endcase
  end

endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: three builds (LATENCY 2, 1, 15) checked against a
// byte-addressed reference memory with randomized and directed traffic.
module tb_dmem_wait;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  int checks   = 0;
  int failures = 0;

  byte unsigned ref_mem [3][256];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  dmem_wait #(.DEPTH(64), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );
  dmem_wait #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );
  dmem_wait #(.DEPTH(64), .LATENCY(15)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_signed(req_signed[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  // Reference: little-endian byte memory of 64 words; faults leave it untouched.
  function automatic void model_access(input int d, input logic we, input logic [1:0] size,
                                       input logic sgn, input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int nbytes;
    logic [31:0] v;
    nbytes = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
    err    = (size == 2'd3) || ((addr % 32'(nbytes)) != 32'd0) || ((addr >> 2) >= 32'd64);
    rdata  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) ref_mem[d][int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[d][int'(addr) + i]) << (8*i));
        if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
        rdata = v;
      end
    end
  endfunction

  // lat = edges after the accept edge until rsp_valid is visible (a consumer
  // registers it one edge later); pulses = cycles rsp_valid was seen high.
  task automatic transact(input int d, input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int pulses);
    int waited;
    lat    = -1;
    pulses = 0;
    rdata  = 32'hxxxx_xxxx;
    err    = 1'bx;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
    req_signed[d] = sgn; req_addr[d] = addr; req_wdata[d] = wdata;
    waited = 0;
    while (!req_ready[d] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready[d]) begin
      req_valid[d] = 1'b0;
      $display("txn dut%0d addr=%h never accepted", d, addr);
      return;
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_size[d] = 2'($urandom);
    req_signed[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[d]) begin
        pulses++;
        if (lat < 0) begin
          lat = n; rdata = rsp_rdata[d]; err = rsp_err[d];
        end
      end
      if (lat >= 0 && n >= lat + 3) break;
    end
    $display("txn dut%0d we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%b lat=%0d pulses=%0d",
             d, we, size, sgn, addr, wdata, rdata, err, lat, pulses);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
      req_signed[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks += 4;
      if (req_ready[d] !== 1'b1) begin failures++; $display("FAIL reset_ready dut%0d got=%b exp=1", d, req_ready[d]); end
      if (rsp_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid dut%0d got=%b exp=0", d, rsp_valid[d]); end
      if (rsp_rdata[d] !== 32'h0) begin failures++; $display("FAIL reset_rdata dut%0d got=%h exp=0", d, rsp_rdata[d]); end
      if (rsp_err[d] !== 1'b0) begin failures++; $display("FAIL reset_err dut%0d got=%b exp=0", d, rsp_err[d]); end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd;
    logic er;
    int lat, pl;
    transact(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, pl);
    checks += 4;
    if (rd !== 32'h0) begin failures++; $display("FAIL word_store_rdata got=%h exp=0", rd); end
    if (er !== 1'b0) begin failures++; $display("FAIL word_store_err got=%b exp=0", er); end
    if (lat != 2) begin failures++; $display("FAIL word_store_latency got=%0d exp=2", lat); end
    if (pl != 1) begin failures++; $display("FAIL word_store_pulses got=%0d exp=1", pl); end
    transact(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, pl);
    checks += 4;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load_rdata got=%h exp=deadbeef", rd); end
    if (er !== 1'b0) begin failures++; $display("FAIL word_load_err got=%b exp=0", er); end
    if (lat != 2) begin failures++; $display("FAIL word_load_latency got=%0d exp=2", lat); end
    if (pl != 1) begin failures++; $display("FAIL word_load_pulses got=%0d exp=1", pl); end
  endtask

  task automatic test_lanes();
    vec_t tbl[$];
    logic [31:0] rd;
    logic er;
    int lat, pl;
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h12, 32'hA5A5A57F, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDE7FBEEF, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h000000DE, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h0000BEEF, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h12, 32'h0,        32'h0000007F, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFFDE7F, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF1234, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1234BEEF, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b1, 32'h10, 32'h0,        32'h1234BEEF, 1'b0});
    foreach (tbl[i]) begin
      transact(0, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, rd, er, lat, pl);
      checks += 3;
      if (rd !== tbl[i].exp) begin failures++; $display("FAIL lanes_rdata[%0d] got=%h exp=%h", i, rd, tbl[i].exp); end
      if (er !== tbl[i].exp_err) begin failures++; $display("FAIL lanes_err[%0d] got=%b exp=%b", i, er, tbl[i].exp_err); end
      if (pl != 1) begin failures++; $display("FAIL lanes_pulses[%0d] got=%0d exp=1", i, pl); end
    end
  endtask

  task automatic test_errors();
    vec_t tbl[$];
    logic [31:0] rd;
    logic er;
    int lat, pl;
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'hFC,  32'h00000000, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h11,  32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h13,  32'h0000FFFF, 32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h11,  32'hFFFFFFFF, 32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1234BEEF, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h10,  32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1234BEEF, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h3FF, 32'h000000FF, 32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'hFC,  32'h0,        32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h11,  32'h0,        32'h00000000, 1'b1});
    foreach (tbl[i]) begin
      transact(0, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, rd, er, lat, pl);
      checks += 3;
      if (rd !== tbl[i].exp) begin failures++; $display("FAIL err_rdata[%0d] got=%h exp=%h", i, rd, tbl[i].exp); end
      if (er !== tbl[i].exp_err) begin failures++; $display("FAIL err_flag[%0d] got=%b exp=%b", i, er, tbl[i].exp_err); end
      if (lat != 2) begin failures++; $display("FAIL err_latency[%0d] got=%0d exp=2", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int nacc, pulses;
    logic r;
    logic [31:0] last_rd;
    acc[0] = -1; acc[1] = -1; nacc = 0; pulses = 0; last_rd = 32'h0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd2;
    req_signed[0] = 1'b0; req_addr[0] = 32'h30; req_wdata[0] = 32'hCAFEF00D;
    for (int k = 0; k < 30; k++) begin
      r = req_ready[0];
      @(posedge clk);
      #1;
      if (r && req_valid[0]) begin
        acc[nacc] = k;
        nacc++;
        if (nacc == 1) begin
          req_we[0] = 1'b0; req_addr[0] = 32'h30; req_wdata[0] = 32'h0;
        end else begin
          req_valid[0] = 1'b0;
        end
      end
      if (rsp_valid[0]) begin
        pulses++;
        last_rd = rsp_rdata[0];
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    $display("txn back_to_back accepts=%0d at k=%0d,%0d pulses=%0d last_rdata=%h",
             nacc, acc[0], acc[1], pulses, last_rd);
    checks += 4;
    if (nacc != 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", nacc); end
    if (acc[1] - acc[0] != lat_of(0) + 2) begin
      failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc[1] - acc[0], lat_of(0) + 2);
    end
    if (pulses != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    if (last_rd !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_rdata got=%h exp=cafef00d", last_rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic er;
    int lat, pl, pulses;
    transact(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, pl);
    transact(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, pl);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd2;
    req_signed[0] = 1'b0; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[0]) pulses++;
    end
    $display("txn reset_abort pulses=%0d ready=%b rdata=%h err=%b", pulses, req_ready[0], rsp_rdata[0], rsp_err[0]);
    checks += 4;
    if (pulses != 0) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", pulses); end
    if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", req_ready[0]); end
    if (rsp_rdata[0] !== 32'h0) begin failures++; $display("FAIL abort_rdata got=%h exp=0", rsp_rdata[0]); end
    if (rsp_err[0] !== 1'b0) begin failures++; $display("FAIL abort_err got=%b exp=0", rsp_err[0]); end
    transact(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, pl);
    checks += 2;
    if (rd !== 32'h0) begin failures++; $display("FAIL abort_no_write got=%h exp=0", rd); end
    if (er !== 1'b0) begin failures++; $display("FAIL abort_load_err got=%b exp=0", er); end
  endtask

  task automatic test_latency_variants();
    logic [31:0] rd, erd, wd, addr;
    logic er, eer, we, sgn;
    logic [1:0] size;
    int lat, pl;
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 14; i++) begin
        if (i < 4) begin
          we = 1'b1; size = 2'd2; sgn = 1'b0; addr = 32'(4 * i);
        end else begin
          we = 1'($urandom); size = 2'($urandom_range(0, 2)); sgn = 1'($urandom);
          addr = 32'($urandom_range(0, 15));
        end
        wd = $urandom;
        model_access(d, we, size, sgn, addr, wd, erd, eer);
        transact(d, we, size, sgn, addr, wd, rd, er, lat, pl);
        checks += 4;
        if (rd !== erd) begin failures++; $display("FAIL lat%0d_rdata[%0d] got=%h exp=%h", lat_of(d), i, rd, erd); end
        if (er !== eer) begin failures++; $display("FAIL lat%0d_err[%0d] got=%b exp=%b", lat_of(d), i, er, eer); end
        if (lat != lat_of(d)) begin failures++; $display("FAIL lat%0d_latency[%0d] got=%0d exp=%0d", lat_of(d), i, lat, lat_of(d)); end
        if (pl != 1) begin failures++; $display("FAIL lat%0d_pulses[%0d] got=%0d exp=1", lat_of(d), i, pl); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, wd, addr;
    logic er, eer, we, sgn;
    logic [1:0] size;
    int lat, pl, r;
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      model_access(0, 1'b1, 2'd2, 1'b0, 32'(4 * w), wd, erd, eer);
      transact(0, 1'b1, 2'd2, 1'b0, 32'(4 * w), wd, rd, er, lat, pl);
      checks++;
      if (er !== 1'b0) begin failures++; $display("FAIL prefill_err[%0d] got=%b exp=0", w, er); end
    end
    for (int i = 0; i < 300; i++) begin
      r    = $urandom_range(0, 15);
      size = (r < 5) ? 2'd0 : ((r < 10) ? 2'd1 : ((r < 15) ? 2'd2 : 2'd3));
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      wd   = $urandom;
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1 && size == 2'd1) addr[0] = 1'b0;
      if ($urandom_range(0, 1) == 1 && size == 2'd2) addr[1:0] = 2'b00;
      model_access(0, we, size, sgn, addr, wd, erd, eer);
      transact(0, we, size, sgn, addr, wd, rd, er, lat, pl);
      checks += 4;
      if (rd !== erd) begin failures++; $display("FAIL rand_rdata[%0d] addr=%h got=%h exp=%h", i, addr, rd, erd); end
      if (er !== eer) begin failures++; $display("FAIL rand_err[%0d] addr=%h got=%b exp=%b", i, addr, er, eer); end
      if (lat != 2) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=2", i, lat); end
      if (pl != 1) begin failures++; $display("FAIL rand_pulses[%0d] got=%0d exp=1", i, pl); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_latency_variants();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
